axis_dest_demux: RTL
====================

# axis_dest_demux

Frame-aware AXI4-Stream router placed directly downstream of the 4-input arbitrated mux. It takes the single merged stream and steers each frame, selected by `tdest` on its first beat, to one of `M_COUNT` output channels. Frames with an out-of-range `tdest` are discarded. A registered output with a one-beat skid buffer sustains one beat per clock and breaks the combinational `tready` path between the mux and the consumers.

## Interface
- `M_COUNT`, 4: number of output channels, 2..16.
- `DATA_WIDTH`, 64: `tdata` width.
- `KEEP_ENABLE`, `(DATA_WIDTH>8)`: carry `tkeep`; when 0, outputs drive all-ones.
- `KEEP_WIDTH`, `(DATA_WIDTH/8)`: `tkeep` width.
- `ID_ENABLE`, 1: carry `tid`; when 0, outputs drive 0.
- `ID_WIDTH`, 8: `tid` width.
- `DEST_WIDTH`, 8: `tdest` width; must be ≥ clog2(`M_COUNT`).
- `USER_ENABLE`, 1: carry `tuser`; when 0, outputs drive 0.
- `USER_WIDTH`, 1: `tuser` width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; **synchronous, active-high**.
- `s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser`  in (tready out)  per params  merged input stream.
- `m_axis_tdata`  out  M_COUNT*DATA_WIDTH  same beat replicated to every lane.
- `m_axis_tkeep`  out  M_COUNT*KEEP_WIDTH  replicated.
- `m_axis_tvalid`  out  M_COUNT  one-hot or zero.
- `m_axis_tready`  in  M_COUNT  per-channel ready.
- `m_axis_tlast`, `m_axis_tid`, `m_axis_tdest`, `m_axis_tuser`  out  M_COUNT × width  replicated; `tdest` is passed through unmodified.
- `drop_frame`  out  1  one-cycle pulse on the first beat of each discarded frame.

## Operation
- FSM with states IDLE, ROUTE and DROP.
- **IDLE:** on an accepted beat, decode `tdest`.
  - `tdest` < `M_COUNT`: latch `sel`=`tdest` and forward the beat.
  - Otherwise: pulse `drop_frame` and consume the beat.
  - Next state, if `tlast`=0: ROUTE or DROP respectively. If `tlast`=1: stay in IDLE.
- **ROUTE:** forward every beat to `sel`, ignoring `tdest`. An accepted `tlast` returns the FSM to IDLE.
- **DROP:** `s_axis_tready`=1 and beats are discarded. An accepted `tlast` returns the FSM to IDLE.
- **Datapath:**
  - Output register: beat fields plus a one-hot valid vector.
  - Temp (skid) register: beat fields plus the channel index.
  - Beat transfer: an accepted beat loads the output register if it is empty or draining this cycle; otherwise it loads temp. Temp moves to the output register when the output register drains.
- **Channel switching:** consecutive frames to different channels are allowed without a bubble. The channel index is stored per buffered beat, so ordering across channels is preserved.
- **Dropped beats** never enter either register.

## Timing
- Reset values: `m_axis_tvalid`=0, `s_axis_tready`=0, `drop_frame`=0, FSM=IDLE, both registers empty. `m_axis_tdata/tkeep/tlast/tid/tdest/tuser` = 0.
- First cycle after `rst` deasserts: `s_axis_tready`=1.
- Latency: a beat accepted at edge N is valid on `m_axis` after edge N; it can be taken at edge N+1.
- `s_axis_tready` is registered and equals "temp empty" for the next cycle. In DROP it is forced to 1, combinationally qualified by state.
- Throughput: one beat/clock with continuous `m_axis_tready`.
- Stall behaviour: after a stall, at most one extra beat is absorbed into temp; then `s_axis_tready`=0.
- Output handshake: `m_axis_tvalid[i]` holds until `m_axis_tready[i]`, with fields stable.
- `tready` on non-selected lanes is ignored.
- `rst` mid-frame clears all state and flushes buffered beats. The remainder of the interrupted frame is treated as a new frame and decoded by the `tdest` of its next beat.
- Simultaneous temp load and output drain in one cycle are handled without loss or duplication.

## Structure
- No shared package is needed. The FSM state encodings are local constants, kept in a common `axis_defs` header only if reused elsewhere.
- One sub-module is natural: `axis_skid_reg`, holding the output and temp registers plus the channel tag, parameterised on payload width.
- The FSM and decode stay in the top module.

## Test plan
- **Basic routing:** 4-beat frame, `tdest`=2, data 0x01..0x04, all `m_axis_tready`=1 → lane 2 only, beats one cycle after acceptance, `tlast` on the 4th; lanes 0, 1 and 3 stay invalid.
- **Drop:** `tdest`=7 with `M_COUNT`=4, 3 beats → `drop_frame` high for 1 cycle, `s_axis_tready` stays 1, no `m_axis_tvalid`. A following frame with `tdest`=0 is routed normally.
- **Back-to-back channels:** single-beat frames with `tdest` 0,1,2,3,0 on consecutive cycles → 5 outputs on the correct lanes in order, no input bubble.
- **Backpressure:** `m_axis_tready[1]`=0 for 5 cycles during an 8-beat frame to lane 1 → exactly one beat absorbed into temp, then `s_axis_tready`=0; after release, all 8 beats arrive intact and in order.
- **Mid-frame reset:** assert `rst` for 1 cycle after beat 2 of a 4-beat frame to lane 3 → all `m_axis_tvalid`=0 the next cycle; the next beat with `tdest`=1 is routed to lane 1.

Source files
------------

// File: rtl/axis_dest_demux_pkg.sv
// -----------------------------------------------------------------------------
// axis_dest_demux_pkg
// Shared definitions for the tdest-routed AXI4-Stream demultiplexer.
//   state_e : frame-level routing FSM state (IDLE / ROUTE / DROP)
// -----------------------------------------------------------------------------
package axis_dest_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

endpackage

// File: rtl/axis_dest_demux_skid.sv
// -----------------------------------------------------------------------------
// axis_dest_demux_skid
// Output register plus one-beat skid (temp) register for the demux. Each
// buffered beat carries its own channel index, so beats for different
// channels stay in order and back-to-back frames to different lanes flow
// without a bubble.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : a routed beat is accepted this cycle
//   payload_i  : packed beat fields of the accepted beat
//   sel_i      : destination channel of the accepted beat
//   ready_o    : registered upstream ready (= temp register empty)
//   payload_o  : packed beat fields of the output register
//   valid_o    : one-hot (or zero) per-channel valid
//   ready_i    : per-channel downstream ready
// -----------------------------------------------------------------------------
module axis_dest_demux_skid #(
  parameter int PAYLOAD_W = 8,
  parameter int M_COUNT   = 4,
  parameter int SEL_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  input  logic [SEL_W-1:0]     sel_i,
  output logic                 ready_o,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic [M_COUNT-1:0]   valid_o,
  input  logic [M_COUNT-1:0]   ready_i
);

  logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
  logic [M_COUNT-1:0]   out_valid_q, out_valid_d;
  logic [PAYLOAD_W-1:0] tmp_payload_q, tmp_payload_d;
  logic [SEL_W-1:0]     tmp_sel_q, tmp_sel_d;
  logic                 tmp_valid_q, tmp_valid_d;
  logic                 ready_q, ready_d;
  logic                 drain;

  function automatic logic [M_COUNT-1:0] lane_onehot(input logic [SEL_W-1:0] s);
    lane_onehot = M_COUNT'(1) << s;
  endfunction

  // Only the selected lane's ready can drain the output register.
  assign drain = |(out_valid_q & ready_i);

  always_comb begin
    out_payload_d = out_payload_q;
    out_valid_d   = out_valid_q;
    tmp_payload_d = tmp_payload_q;
    tmp_sel_d     = tmp_sel_q;
    tmp_valid_d   = tmp_valid_q;

    if (drain) out_valid_d = '0;

    if (load_i) begin
      // Upstream ready implies temp is empty, so a new beat never has to
      // compete with a parked one.
      if (!(|out_valid_q) || drain) begin
        out_payload_d = payload_i;
        out_valid_d   = lane_onehot(sel_i);
      end else begin
        tmp_payload_d = payload_i;
        tmp_sel_d     = sel_i;
        tmp_valid_d   = 1'b1;
      end
    end else if (drain && tmp_valid_q) begin
      out_payload_d = tmp_payload_q;
      out_valid_d   = lane_onehot(tmp_sel_q);
      tmp_valid_d   = 1'b0;
    end

    ready_d = !tmp_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_payload_q <= '0;
      out_valid_q   <= '0;
      tmp_valid_q   <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      out_payload_q <= out_payload_d;
      out_valid_q   <= out_valid_d;
      tmp_valid_q   <= tmp_valid_d;
      ready_q       <= ready_d;
    end
  end

  // Temp contents are meaningless while tmp_valid_q is low.
  always_ff @(posedge clk) begin
    tmp_payload_q <= tmp_payload_d;
    tmp_sel_q     <= tmp_sel_d;
  end

  assign ready_o   = ready_q;
  assign payload_o = out_payload_q;
  assign valid_o   = out_valid_q;

endmodule

// File: rtl/axis_dest_demux.sv
// -----------------------------------------------------------------------------
// axis_dest_demux
// Frame-aware AXI4-Stream router. The tdest of each frame's first beat picks
// one of M_COUNT output channels; frames with an out-of-range tdest are
// consumed and discarded. The output side is fully registered with a one-beat
// skid buffer so s_axis_tready does not depend combinationally on
// m_axis_tready.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   s_axis_*        : merged input stream
//   m_axis_*        : M_COUNT output lanes; payload replicated on every lane,
//                     m_axis_tvalid one-hot or zero
//   drop_frame      : one-cycle pulse for each discarded frame
// -----------------------------------------------------------------------------
module axis_dest_demux
  import axis_dest_demux_pkg::*;
#(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int ID_ENABLE   = 1,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                             clk,
  input  logic                             rst,

  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  input  logic [ID_WIDTH-1:0]              s_axis_tid,
  input  logic [DEST_WIDTH-1:0]            s_axis_tdest,
  input  logic [USER_WIDTH-1:0]            s_axis_tuser,

  output logic [M_COUNT*DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]    m_axis_tkeep,
  output logic [M_COUNT-1:0]               m_axis_tvalid,
  input  logic [M_COUNT-1:0]               m_axis_tready,
  output logic [M_COUNT-1:0]               m_axis_tlast,
  output logic [M_COUNT*ID_WIDTH-1:0]      m_axis_tid,
  output logic [M_COUNT*DEST_WIDTH-1:0]    m_axis_tdest,
  output logic [M_COUNT*USER_WIDTH-1:0]    m_axis_tuser,

  output logic                             drop_frame
);

  localparam int SEL_W     = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
  localparam int PAYLOAD_W = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam logic [DEST_WIDTH:0] DEST_LIMIT = (DEST_WIDTH + 1)'(M_COUNT);

  state_e            state_q;
  logic [SEL_W-1:0]  sel_q;
  logic              drop_q;

  logic              skid_ready;
  logic              accept;
  logic              in_range;
  logic              load;
  logic [SEL_W-1:0]  load_sel;

  logic [KEEP_WIDTH-1:0] keep_in;
  logic [ID_WIDTH-1:0]   id_in;
  logic [USER_WIDTH-1:0] user_in;
  logic [PAYLOAD_W-1:0]  payload_in;
  logic [PAYLOAD_W-1:0]  payload_out;

  logic [DATA_WIDTH-1:0] out_data;
  logic [KEEP_WIDTH-1:0] out_keep;
  logic                  out_last;
  logic [ID_WIDTH-1:0]   out_id;
  logic [DEST_WIDTH-1:0] out_dest;
  logic [USER_WIDTH-1:0] out_user;

  // Disabled sideband fields are replaced by constants before buffering.
  assign keep_in = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;
  assign id_in   = (ID_ENABLE   != 0) ? s_axis_tid   : '0;
  assign user_in = (USER_ENABLE != 0) ? s_axis_tuser : '0;

  assign in_range = ({1'b0, s_axis_tdest} < DEST_LIMIT);

  // Dropped frames are sunk at full rate regardless of buffer occupancy.
  assign s_axis_tready = (state_q == ST_DROP) || skid_ready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign load          = accept && (((state_q == ST_IDLE) && in_range) || (state_q == ST_ROUTE));
  assign load_sel      = (state_q == ST_IDLE) ? s_axis_tdest[SEL_W-1:0] : sel_q;

  assign payload_in = {s_axis_tdata, keep_in, s_axis_tlast, id_in, s_axis_tdest, user_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (in_range) begin
              sel_q <= load_sel;
              if (!s_axis_tlast) state_q <= ST_ROUTE;
            end else begin
              drop_q <= 1'b1;
              if (!s_axis_tlast) state_q <= ST_DROP;
            end
          end
        end
        ST_ROUTE, ST_DROP: begin
          if (accept && s_axis_tlast) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  axis_dest_demux_skid #(
    .PAYLOAD_W (PAYLOAD_W),
    .M_COUNT   (M_COUNT),
    .SEL_W     (SEL_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .payload_i (payload_in),
    .sel_i     (load_sel),
    .ready_o   (skid_ready),
    .payload_o (payload_out),
    .valid_o   (m_axis_tvalid),
    .ready_i   (m_axis_tready)
  );

  assign {out_data, out_keep, out_last, out_id, out_dest, out_user} = payload_out;

  assign m_axis_tdata = {M_COUNT{out_data}};
  assign m_axis_tkeep = {M_COUNT{out_keep}};
  assign m_axis_tlast = {M_COUNT{out_last}};
  assign m_axis_tid   = {M_COUNT{out_id}};
  assign m_axis_tdest = {M_COUNT{out_dest}};
  assign m_axis_tuser = {M_COUNT{out_user}};
  assign drop_frame   = drop_q;

endmodule
